// File: rtl/ppg_pkg.sv
// Shared definitions for the PPG phase sequencer: FSM encoding, phase codes,
// data widths and the subtract-and-clamp helper.
package ppg_pkg;

    localparam int ADC_W = 8;
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IR_SETTLE,
        S_IR_SAMPLE,
        S_RED_SETTLE,
        S_RED_SAMPLE,
        S_DARK_SETTLE,
        S_DARK_SAMPLE,
        S_FRAME_END
    } state_t;

    localparam logic [1:0] PHASE_IDLE = 2'd0;
    localparam logic [1:0] PHASE_IR   = 2'd1;
    localparam logic [1:0] PHASE_RED  = 2'd2;
    localparam logic [1:0] PHASE_DARK = 2'd3;

    // Phase code reported for a state; FRAME_END reports idle.
    function automatic logic [1:0] state_phase(input state_t s);
        case (s)
            S_IR_SETTLE, S_IR_SAMPLE:     return PHASE_IR;
            S_RED_SETTLE, S_RED_SAMPLE:   return PHASE_RED;
            S_DARK_SETTLE, S_DARK_SAMPLE: return PHASE_DARK;
            default:                      return PHASE_IDLE;
        endcase
    endfunction

    // Ambient subtraction that saturates at zero instead of wrapping.
    function automatic logic [ADC_W-1:0] sub_clamp(input logic [ADC_W-1:0] a,
                                                   input logic [ADC_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/ppg_avg_accum.sv
// Per-phase sample accumulator. avg reflects the sum including the sample
// being added this cycle, so the top can latch a complete average on the
// same edge that ends the sampling burst.
module ppg_avg_accum
    import ppg_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             add_en,
    input  logic [ADC_W-1:0] ADC,
    output logic [ADC_W-1:0] avg
);

    localparam int ACC_W = ADC_W + AVG_LOG2;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum_next;

    // 2**AVG_LOG2 samples of at most 255 always fit in ACC_W bits.
    assign sum_next = acc + (add_en ? ACC_W'(ADC) : '0);
    assign avg      = ADC_W'(sum_next >> AVG_LOG2);

    // Accumulate while sampling; cleared throughout the phase's settle state.
    // NOTE: the accumulator is a plain register, not a memory, so it takes
    // the async reset like every other flop here.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (add_en) begin
            acc <= sum_next;
        end
    end

endmodule

// File: rtl/ppg_phase_sequencer.sv
// Pulse-oximeter LED sequencer: IR, RED and optional dark phase per frame,
// each a settle interval followed by an averaged ADC burst; publishes
// ambient-corrected averages with a one-cycle valid strobe.
module ppg_phase_sequencer
    import ppg_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int AVG_LOG2   = 2,
    parameter bit DARK_EN    = 1'b1,
    parameter int CLKF_DIV   = 2
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [ADC_W-1:0] ADC,
    output logic             LED_IR,
    output logic             LED_RED,
    output logic             CLK_Filter,
    output logic [1:0]       phase,
    output logic [ADC_W-1:0] IR_ADC_Value,
    output logic [ADC_W-1:0] RED_ADC_Value,
    output logic [ADC_W-1:0] DARK_ADC_Value,
    output logic             sample_valid
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [CNT_W-1:0] CLKF_LAST   = CNT_W'(CLKF_DIV - 1);

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_cnt;
    logic             is_settle;
    logic             last;
    logic [ADC_W-1:0] ir_avg, red_avg, dark_avg;

    assign is_settle = (state == S_IR_SETTLE) || (state == S_RED_SETTLE) ||
                       (state == S_DARK_SETTLE);
    assign last      = is_settle ? (cnt == SETTLE_LAST) : (cnt == SAMPLE_LAST);

    ppg_avg_accum #(.AVG_LOG2(AVG_LOG2)) u_ir_acc (
        .CLK(CLK), .rst_n(rst_n),
        .clear(state == S_IR_SETTLE), .add_en(state == S_IR_SAMPLE),
        .ADC(ADC), .avg(ir_avg)
    );

    ppg_avg_accum #(.AVG_LOG2(AVG_LOG2)) u_red_acc (
        .CLK(CLK), .rst_n(rst_n),
        .clear(state == S_RED_SETTLE), .add_en(state == S_RED_SAMPLE),
        .ADC(ADC), .avg(red_avg)
    );

    ppg_avg_accum #(.AVG_LOG2(AVG_LOG2)) u_dark_acc (
        .CLK(CLK), .rst_n(rst_n),
        .clear(state == S_DARK_SETTLE), .add_en(state == S_DARK_SAMPLE),
        .ADC(ADC), .avg(dark_avg)
    );

    // State register.
    // NOTE: sequential blocks use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state decode: walk the frame, advancing when the interval ends.
    // NOTE: next_state is defaulted first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:        if (enable) next_state = S_IR_SETTLE;
            S_IR_SETTLE:   if (last) next_state = S_IR_SAMPLE;
            S_IR_SAMPLE:   if (last) next_state = S_RED_SETTLE;
            S_RED_SETTLE:  if (last) next_state = S_RED_SAMPLE;
            S_RED_SAMPLE:  if (last) next_state = DARK_EN ? S_DARK_SETTLE : S_FRAME_END;
            S_DARK_SETTLE: if (last) next_state = S_DARK_SAMPLE;
            S_DARK_SAMPLE: if (last) next_state = S_FRAME_END;
            S_FRAME_END:   next_state = enable ? S_IR_SETTLE : S_IDLE;
            default:       next_state = S_IDLE;
        endcase
    end

    // Cycle counter within a settle/sample interval; restarts on every state change.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if ((next_state != state) || (state == S_IDLE) || (state == S_FRAME_END)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Registered LEDs/phase follow the state being entered; results latch on FRAME_END entry.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            LED_IR         <= 1'b0;
            LED_RED        <= 1'b0;
            phase          <= PHASE_IDLE;
            sample_valid   <= 1'b0;
            IR_ADC_Value   <= '0;
            RED_ADC_Value  <= '0;
            DARK_ADC_Value <= '0;
        end else begin
            LED_IR       <= next_state inside {S_IR_SETTLE, S_IR_SAMPLE};
            LED_RED      <= next_state inside {S_RED_SETTLE, S_RED_SAMPLE};
            phase        <= state_phase(next_state);
            sample_valid <= (next_state == S_FRAME_END);
            if (next_state == S_FRAME_END) begin
                IR_ADC_Value   <= DARK_EN ? sub_clamp(ir_avg, dark_avg) : ir_avg;
                RED_ADC_Value  <= DARK_EN ? sub_clamp(red_avg, dark_avg) : red_avg;
                DARK_ADC_Value <= DARK_EN ? dark_avg : '0;
            end
        end
    end

    // Free-running filter clock: toggle every CLKF_DIV cycles.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            CLK_Filter <= 1'b0;
        end else if (div_cnt == CLKF_LAST) begin
            div_cnt    <= '0;
            CLK_Filter <= ~CLK_Filter;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

endmodule
